// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks a 4-input combinational block through all 16
// input combinations, captures its output into a truth table and compares the
// result against an expected constant.
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hE8C8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [4:0]  mismatch_cnt,
  output logic        fail_valid,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Last value of the wait counter before sampling; the counter starts at 0.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [3:0] wait_cnt;
  logic       settle_end;
  logic       sample_miss;
  logic       start_acc;

  assign settle_end  = (wait_cnt == SETTLE_LAST);
  assign sample_miss = (f_in != EXPECTED[idx]);
  assign start_acc   = (state == S_IDLE) && start;

  // idx is cleared whenever the FSM is not scanning, so it doubles as the
  // registered stimulus and reads 0000 in IDLE and DONE.
  assign {a, b, c, d} = idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore outputs busy/done.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_end) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy = 1'b1;
        if (idx == 4'd15) state_nxt = S_DONE;
        else              state_nxt = S_SETTLE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scan datapath: index/wait counters, capture and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= 4'd0;
      wait_cnt       <= 4'd0;
      table_out      <= 16'h0000;
      match          <= 1'b0;
      mismatch_cnt   <= 5'd0;
      fail_valid     <= 1'b0;
      first_fail_idx <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            idx            <= 4'd0;
            wait_cnt       <= 4'd0;
            table_out      <= 16'h0000;
            match          <= 1'b0;
            mismatch_cnt   <= 5'd0;
            fail_valid     <= 1'b0;
            first_fail_idx <= 4'd0;
          end
        end
        S_SETTLE: begin
          wait_cnt <= settle_end ? 4'd0 : wait_cnt + 4'd1;
        end
        S_SAMPLE: begin
          table_out[idx] <= f_in;
          wait_cnt       <= 4'd0;
          if (sample_miss) begin
            mismatch_cnt <= mismatch_cnt + 5'd1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= idx;
            end
          end
          // Final index returns the stimulus to 0000 for DONE.
          idx <= (idx == 4'd15) ? 4'd0 : idx + 4'd1;
        end
        S_DONE: begin
          match <= (table_out == EXPECTED);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) driven
// by a truth-table model of the block under test, checked cycle by cycle
// against a timing/result reference derived from the scan rules.
module tb_truth_table_scanner;

  localparam logic [15:0] EXP = 16'hE8C8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_req;
  logic        sel3;
  logic [15:0] fn_tab;

  logic        start1, f1, a1, b1, c1, d1, busy1, done1, match1, fv1;
  logic [15:0] tab1;
  logic [4:0]  mc1;
  logic [3:0]  ffi1;

  logic        start3, f3, a3, b3, c3, d3, busy3, done3, match3, fv3;
  logic [15:0] tab3;
  logic [4:0]  mc3;
  logic [3:0]  ffi3;

  int vectors;
  int miscompares;

  assign start1 = start_req & ~sel3;
  assign start3 = start_req &  sel3;
  // Model of the function block under test: a lookup of the current stimulus.
  assign f1 = fn_tab[{a1, b1, c1, d1}];
  assign f3 = fn_tab[{a3, b3, c3, d3}];

  truth_table_scanner dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .table_out(tab1), .match(match1), .mismatch_cnt(mc1),
    .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .table_out(tab3), .match(match3), .mismatch_cnt(mc3),
    .fail_valid(fv3), .first_fail_idx(ffi3)
  );

  logic [3:0]  cur_abcd;
  logic        cur_busy, cur_done, cur_match, cur_fv;
  logic [15:0] cur_tab;
  logic [4:0]  cur_mc;
  logic [3:0]  cur_ffi;

  always_comb begin
    cur_abcd  = {a1, b1, c1, d1};
    cur_busy  = busy1;
    cur_done  = done1;
    cur_match = match1;
    cur_fv    = fv1;
    cur_tab   = tab1;
    cur_mc    = mc1;
    cur_ffi   = ffi1;
    if (sel3) begin
      cur_abcd  = {a3, b3, c3, d3};
      cur_busy  = busy3;
      cur_done  = done3;
      cur_match = match3;
      cur_fv    = fv3;
      cur_tab   = tab3;
      cur_mc    = mc3;
      cur_ffi   = ffi3;
    end
  end

  // f = BC + CD + ABD evaluated for every index {A,B,C,D}.
  function automatic logic [15:0] spec_table();
    logic [15:0] t;
    logic [3:0]  v;
    t = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      v    = 4'(i);
      t[i] = (v[2] & v[1]) | (v[1] & v[0]) | (v[3] & v[2] & v[0]);
    end
    return t;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] x);
    for (int i = 15; i >= 0; i--) begin
      if (x[i]) lowest_set = 4'(i);
    end
    if (x == 16'h0000) lowest_set = 4'd0;
  endfunction

  task automatic check_reset_vals(input string name);
    vectors++;
    if ({a1, b1, c1, d1, busy1, done1, tab1, match1, mc1, fv1, ffi1} !== 33'd0) begin
      miscompares++;
      $display("FAIL %s dut1: abcd=%h busy=%b done=%b tab=%h match=%b cnt=%0d fv=%b ffi=%0d, all must be 0",
               name, {a1, b1, c1, d1}, busy1, done1, tab1, match1, mc1, fv1, ffi1);
    end
    vectors++;
    if ({a3, b3, c3, d3, busy3, done3, tab3, match3, mc3, fv3, ffi3} !== 33'd0) begin
      miscompares++;
      $display("FAIL %s dut3: abcd=%h busy=%b done=%b tab=%h match=%b cnt=%0d fv=%b ffi=%0d, all must be 0",
               name, {a3, b3, c3, d3}, busy3, done3, tab3, match3, mc3, fv3, ffi3);
    end
  endtask

  // One complete scan; k counts rising edges after the accepting edge E0 and
  // every check happens on the falling edge after edge E0+k.
  task automatic run_scan(input bit s3, input logic [15:0] tab, input bit extra_starts,
                          input string name);
    int          per;
    int          last;
    int          done_seen;
    logic [3:0]  exp_idx;
    logic        exp_busy, exp_done;
    logic [15:0] diff;
    per  = (s3 ? 3 : 1) + 1;
    last = 16 * per;
    diff = tab ^ EXP;
    done_seen = 0;
    sel3   = s3;
    fn_tab = tab;
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_req = 1'b0;
    for (int k = 0; k <= last + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (extra_starts && (k == 9 || k == last)) start_req = 1'b1;
      if (extra_starts && (k == 10 || k == last + 1)) start_req = 1'b0;
      exp_idx  = (k < last) ? 4'(k / per) : 4'd0;
      exp_busy = (k < last);
      exp_done = (k == last);
      if (cur_done) done_seen++;
      vectors++;
      if ({cur_abcd, cur_busy, cur_done} !== {exp_idx, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL %s E0+%0d abcd/busy/done: got %h/%b/%b, want %h/%b/%b",
                 name, k, cur_abcd, cur_busy, cur_done, exp_idx, exp_busy, exp_done);
      end
      if (k == 0) begin
        vectors++;
        if ({cur_tab, cur_match, cur_mc, cur_fv} !== 23'd0) begin
          miscompares++;
          $display("FAIL %s start_clear: tab=%h match=%b cnt=%0d fv=%b, want all 0",
                   name, cur_tab, cur_match, cur_mc, cur_fv);
        end
      end
      if (k == last || k == last + 2) begin
        vectors++;
        if ({cur_tab, cur_mc, cur_fv} !== {tab, 5'($countones(diff)), diff != 16'h0}) begin
          miscompares++;
          $display("FAIL %s results E0+%0d: tab=%h cnt=%0d fv=%b, want tab=%h cnt=%0d fv=%b",
                   name, k, cur_tab, cur_mc, cur_fv, tab, $countones(diff), diff != 16'h0);
        end
        if (diff != 16'h0) begin
          vectors++;
          if (cur_ffi !== lowest_set(diff)) begin
            miscompares++;
            $display("FAIL %s first_fail_idx: got %0d, want %0d", name, cur_ffi, lowest_set(diff));
          end
        end
      end
      if (k >= last + 1) begin
        vectors++;
        if (cur_match !== (tab == EXP)) begin
          miscompares++;
          $display("FAIL %s match E0+%0d: got %b, want %b", name, k, cur_match, tab == EXP);
        end
      end
    end
    vectors++;
    if (done_seen != 1) begin
      miscompares++;
      $display("FAIL %s done_pulses: got %0d, want 1", name, done_seen);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_req = 1'b0;
    sel3 = 1'b0;
    fn_tab = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_correct_function();
    run_scan(1'b0, spec_table(), 1'b0, "correct_s1");
  endtask

  task automatic test_stuck();
    run_scan(1'b0, 16'h0000, 1'b0, "stuck0");
    run_scan(1'b0, 16'hFFFF, 1'b0, "stuck1");
  endtask

  task automatic test_settle3();
    run_scan(1'b1, spec_table(), 1'b0, "correct_s3");
    run_scan(1'b1, 16'h0000, 1'b0, "stuck0_s3");
  endtask

  task automatic test_start_ignored();
    run_scan(1'b0, spec_table(), 1'b1, "start_ignored");
  endtask

  task automatic test_random();
    logic [15:0] t;
    for (int n = 0; n < 6; n++) begin
      t = 16'($urandom);
      if (n == 0) t = EXP ^ 16'h8000;
      run_scan(n[0], t, n[1], "random");
    end
  endtask

  task automatic test_reset_mid_scan();
    sel3   = 1'b0;
    fn_tab = 16'h0000;
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_req = 1'b0;
    repeat (15) @(negedge clk);
    // Indices 0..6 sampled so far; 3 and 6 disagree with the expected table.
    vectors++;
    if ({mc1, fv1, ffi1, busy1} !== {5'd2, 1'b1, 4'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_scan_partial: cnt=%0d fv=%b ffi=%0d busy=%b, want 2/1/3/1",
               mc1, fv1, ffi1, busy1);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b0, spec_table(), 1'b0, "post_reset");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_correct_function();
    test_stuck();
    test_settle3();
    test_start_ignored();
    test_random();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture stage that sits directly upstream of the 4-input POS/NOR function block. It drives the function's A, B, C and D inputs through all 16 combinations and samples the returned `f` for each one. It assembles a 16-bit truth table and compares it against an expected constant, so the combinational stage can be checked on hardware without a bench.

## Interface
- `SETTLE`, default 1: cycles each input vector is held before `f_in` is sampled. Legal range is 1..15; 0 is illegal.
- `EXPECTED`, default 16'hE8C8: expected truth table. Bit i is `f` for index i = {A,B,C,D}, with A as the MSB.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a scan; sampled on the rising edge.
- `f_in` in 1: `f` returned by the function block under test.
- `a`, `b`, `c`, `d` out 1 each: registered stimulus, equal to {a,b,c,d} = current index.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: one-cycle pulse when the scan completes.
- `table_out` out 16: captured truth table; bit i is `f_in` sampled at index i.
- `match` out 1: `table_out == EXPECTED`; valid from `done` until the next `start`.
- `mismatch_cnt` out 5: number of indices where the sample differs from the `EXPECTED` bit (0..16).
- `fail_valid` out 1: at least one mismatch has been seen.
- `first_fail_idx` out 4: lowest index that mismatched; valid only when `fail_valid` = 1.

## Operation
- FSM states are IDLE, SETTLE, SAMPLE and DONE.
- IDLE:
  - stimulus {a,b,c,d} = 0000; `busy` = 0.
  - `start` = 1 moves to SETTLE with idx = 0 and wait counter = 0.
  - On that same edge it clears `table_out`, `mismatch_cnt`, `fail_valid`, `first_fail_idx` and `match`.
- SETTLE:
  - drives {a,b,c,d} = idx; `busy` = 1.
  - The wait counter increments each cycle.
  - After the SETTLE-th cycle in this state, moves to SAMPLE.
- SAMPLE:
  - drives {a,b,c,d} = idx; `busy` = 1.
  - On the edge ending this cycle: `table_out[idx]` <= `f_in`.
  - If `f_in` != `EXPECTED[idx]`: `mismatch_cnt` increments. If `fail_valid` was 0, set `fail_valid` = 1 and `first_fail_idx` = idx.
  - If idx == 15, move to DONE. Otherwise idx increments and the FSM returns to SETTLE with the wait counter cleared.
- DONE:
  - `done` = 1 and `busy` = 0; stimulus returns to 0000.
  - `match` <= (`table_out == EXPECTED`), registered on exit.
  - Always returns to IDLE after one cycle.
- `start` is ignored in SETTLE, SAMPLE and DONE; there is no queuing.
- Results (`table_out`, `match`, `mismatch_cnt`, `fail_valid`, `first_fail_idx`) hold their values in IDLE until the next accepted `start`.
- idx is 4 bits and never wraps: the scan ends at 15.
- `mismatch_cnt` is 5 bits, so 16 mismatches do not overflow.

## Timing
- Reset values:
  - state = IDLE; `a`, `b`, `c`, `d` = 0; `busy` = 0; `done` = 0.
  - `table_out` = 16'h0000; `match` = 0; `mismatch_cnt` = 0; `fail_valid` = 0; `first_fail_idx` = 0.
- Asserting `rst_n` low mid-scan forces all reset values immediately, without waiting for a clock edge. No partial result is retained.
- Let E0 be the edge on which `start` is accepted. The scan then proceeds as follows:
  - Index i is driven from edge E0 + i·(SETTLE+1).
  - Index i is sampled on edge E0 + (i+1)·(SETTLE+1).
  - The stimulus is stable for SETTLE+1 cycles before the sampling edge.
- `done` is high for the single cycle following edge E0 + 16·(SETTLE+1). For SETTLE = 1, that is the cycle after edge E0+32.
- `busy` rises after E0 and falls on the same edge that raises `done`.
- `match` becomes valid on the edge ending the DONE cycle and stays valid in IDLE.
- `f_in` must be settled combinationally from {a,b,c,d} within one cycle; the SETTLE ≥ 1 requirement guarantees this.

## Test plan
- **Correct function:**
  - Stimulus: reset, then `start` for one cycle; `f_in` driven by a model of f = BC + CD + ABD.
  - Required: `done` at E0+32; `table_out` = 16'hE8C8; `match` = 1; `mismatch_cnt` = 0; `fail_valid` = 0.
- **Stuck-at-0 output:**
  - Stimulus: `f_in` tied to 0.
  - Required: `table_out` = 16'h0000; `mismatch_cnt` = 7; `first_fail_idx` = 3; `match` = 0.
- **Stuck-at-1 output:**
  - Stimulus: `f_in` tied to 1.
  - Required: `table_out` = 16'hFFFF; `mismatch_cnt` = 9; `first_fail_idx` = 0.
- **Stimulus sequence and timing:**
  - Stimulus: SETTLE = 3.
  - Required: {a,b,c,d} steps 0..15, each held exactly 4 cycles; `done` at E0+64.
- **`start` ignored while busy:**
  - Stimulus: pulse `start` at E0+10 and again during DONE.
  - Required: no restart; `done` still at E0+32; exactly one `done` pulse.
- **Reset mid-scan:**
  - Stimulus: drop `rst_n` at E0+15, release, then start a new scan.
  - Required: all outputs return to reset values immediately, without a clock edge; the new scan gives 16'hE8C8 and `match` = 1.
